// File: rtl/osc_pkg.sv
// Shared types and helpers for the osc_bank multi-channel square-wave generator.
package osc_pkg;

  typedef enum logic [1:0] {OSC_DIS, OSC_HI, OSC_LO} osc_state_t;

  localparam int OSC_DEF_LEN = 1;

  // Select width for a channel index, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osc_channel.sv
// One oscillator channel: DIS/HI/LO FSM, phase counter, current/pending lengths.
// OSC_ASYM_EN builds a separate low-phase length; otherwise low = high (50 % duty).
module osc_channel import osc_pkg::*; #(
  parameter int W       = 8,
  parameter int DEF_LEN = OSC_DEF_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] cfg_hi,
  input  logic [W-1:0] cfg_lo,
  output logic         pend,
  output logic         osc,
  output logic         tick
);

  osc_state_t   state, state_d;
  logic [W-1:0] cnt, cnt_d, cur_hi, pend_hi, hi_use, hi_eff, lo_eff, len;
  logic         osc_d, tick_d, wrap, apply;

`ifdef OSC_ASYM_EN
  logic [W-1:0] cur_lo, pend_lo;
  assign lo_eff = (cur_lo == '0) ? W'(1) : cur_lo;
`else
  logic unused_lo;
  assign unused_lo = ^cfg_lo;
  assign lo_eff    = (cur_hi == '0) ? W'(1) : cur_hi;
`endif

  // A pending update on a disabled channel takes effect on this edge, so an
  // enable on the same edge already counts with the new high length.
  assign hi_use = (state == OSC_DIS && pend) ? pend_hi : cur_hi;
  assign hi_eff = (hi_use == '0) ? W'(1) : hi_use;
  assign len    = (state == OSC_LO) ? lo_eff : hi_eff;
  assign wrap   = en && (cnt == len - W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= OSC_DIS;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!en)                   state_d = OSC_DIS;
    else if (wrap)             state_d = (state == OSC_LO) ? OSC_HI : OSC_LO;
    else if (state == OSC_DIS) state_d = OSC_HI;
  end

  always_comb begin
    cnt_d  = (en && !wrap) ? cnt + W'(1) : '0;
    osc_d  = !en ? 1'b1 : (wrap ? ~osc : osc);
    tick_d = (osc_d != osc);
    apply  = pend && (state == OSC_DIS || wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      osc     <= 1'b1;
      tick    <= 1'b0;
      cur_hi  <= W'(DEF_LEN);
      pend_hi <= '0;
      pend    <= 1'b0;
`ifdef OSC_ASYM_EN
      cur_lo  <= W'(DEF_LEN);
      pend_lo <= '0;
`endif
    end else begin
      cnt  <= cnt_d;
      osc  <= osc_d;
      tick <= tick_d;
      if (apply) begin
        cur_hi <= pend_hi;
`ifdef OSC_ASYM_EN
        cur_lo <= pend_lo;
`endif
      end
      // wr only fires while pend is clear and apply only while it is set.
      if (wr) begin
        pend_hi <= cfg_hi;
`ifdef OSC_ASYM_EN
        pend_lo <= cfg_lo;
`endif
        pend    <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/osc_bank.sv
// CH independent programmable square-wave channels with a shared config port.
// OSC_ASYM_EN enables independent low-phase lengths (see osc_channel).
module osc_bank import osc_pkg::*; #(
  parameter int CH      = 4,
  parameter int W       = 8,
  parameter int DEF_LEN = OSC_DEF_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         en,
  input  logic                  cfg_valid,
  input  logic [sel_w(CH)-1:0]  cfg_ch,
  input  logic [W-1:0]          cfg_hi,
  input  logic [W-1:0]          cfg_lo,
  output logic                  cfg_ready,
  output logic [CH-1:0]         osc,
  output logic [CH-1:0]         tick
);

  localparam int SW = sel_w(CH);

  logic [CH-1:0] pend, hit, wr;

  // Out-of-range channels are always ready; their writes land nowhere.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CH; i++)
      if (cfg_ch == SW'(i)) cfg_ready = ~pend[i];
  end

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      assign hit[i] = (cfg_ch == SW'(i));
      assign wr[i]  = cfg_valid & cfg_ready & hit[i];

      osc_channel #(.W(W), .DEF_LEN(DEF_LEN)) u_ch (
        .clk    (clk),
        .rst    (rst),
        .en     (en[i]),
        .wr     (wr[i]),
        .cfg_hi (cfg_hi),
        .cfg_lo (cfg_lo),
        .pend   (pend[i]),
        .osc    (osc[i]),
        .tick   (tick[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_osc_bank.sv
// Scoreboard bench for osc_bank: a phase-countdown model pushes expected osc/tick per edge.
module tb_osc_bank;

  localparam int CH  = 5;
  localparam int W   = 8;
  localparam int DEF = 1;
  localparam int SW  = osc_pkg::sel_w(CH);

  logic          clk = 1'b0;
  logic          rst, cfg_valid, cfg_ready;
  logic [CH-1:0] en, osc, tick;
  logic [SW-1:0] cfg_ch;
  logic [W-1:0]  cfg_hi, cfg_lo;

  typedef struct packed {
    logic [CH-1:0] osc;
    logic [CH-1:0] tick;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0, nerr = 0;

  int            m_hi[CH], m_lo[CH], m_phi[CH], m_plo[CH], m_rem[CH];
  logic [CH-1:0] m_osc, m_tick, m_run, m_pend;
  int            track2 = 0, run2 = 0, min2 = 1000;

  osc_bank #(.CH(CH), .W(W), .DEF_LEN(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .cfg_ready(cfg_ready), .osc(osc), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int lo_of(input int i);
`ifdef OSC_ASYM_EN
    return m_lo[i];
`else
    return m_hi[i];
`endif
  endfunction

  function automatic logic m_ready();
    logic r = 1'b1;
    for (int i = 0; i < CH; i++)
      if (int'(cfg_ch) == i) r = ~m_pend[i];
    return r;
  endfunction

  task automatic m_apply(input int i);
    m_hi[i]   = m_phi[i];
    m_lo[i]   = m_plo[i];
    m_pend[i] = 1'b0;
  endtask

  // Model: each running phase loads its length and counts down to the toggle.
  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      logic xfer, old;
      if (rst) begin
        m_osc[i] = 1'b1; m_tick[i] = 1'b0; m_run[i] = 1'b0; m_pend[i] = 1'b0;
        m_hi[i] = DEF; m_lo[i] = DEF; m_rem[i] = 0;
        continue;
      end
      xfer = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
      old  = m_osc[i];
      if (!m_run[i] && m_pend[i]) m_apply(i);
      if (!en[i]) begin
        m_run[i] = 1'b0;
        m_osc[i] = 1'b1;
      end else begin
        if (!m_run[i]) begin
          m_run[i] = 1'b1;
          m_rem[i] = eff(m_hi[i]);
        end
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_osc[i] = ~m_osc[i];
          if (m_pend[i]) m_apply(i);
          m_rem[i] = m_osc[i] ? eff(m_hi[i]) : eff(lo_of(i));
        end
      end
      m_tick[i] = (m_osc[i] != old);
      if (xfer) begin
        m_pend[i] = 1'b1;
        m_phi[i]  = int'(cfg_hi);
        m_plo[i]  = int'(cfg_lo);
      end
    end
  endtask

  task automatic step();
    exp_t e;
    #1;
    chk("cfg_ready", cfg_ready, m_ready());
    model_edge();
    e.osc = m_osc; e.tick = m_tick;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("osc", osc, e.osc);
    chk("tick", tick, e.tick);
    if (track2 != 0) begin
      if (tick[2]) begin
        if (track2 == 2 && run2 + 1 < min2) min2 = run2 + 1;
        track2 = 2;
        run2   = 0;
      end else begin
        run2++;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg(input int ch, input int hi, input int lo);
    cfg_valid = 1'b1;
    cfg_ch    = SW'(ch);
    cfg_hi    = W'(hi);
    cfg_lo    = W'(lo);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_hi = '0; cfg_lo = '0;
    steps(2);
    rst = 1'b0;
    chk("rst_osc", osc, {CH{1'b1}});
    chk("rst_tick", tick, '0);
    chk("rst_ready", cfg_ready, 1'b1);
    steps(20);

    // clk/2 on ch0 with default lengths
    en[0] = 1'b1;
    step();
    chk("ch0_fall_k", osc[0], 1'b0);
    steps(5);

    // ch1 configured while disabled, then a second request right after
    cfg(1, 3, 5);
    step();
    #1 chk("ch1_ready2", cfg_ready, 1'b1);
    cfg(1, 3, 5);
    step();
    en[1] = 1'b1;
    steps(2);
    chk("ch1_hi_k1", osc[1], 1'b1);
    step();
    chk("ch1_fall_k2", osc[1], 1'b0);
    steps(16);

    // ch2 update mid-high-phase
    cfg(2, 4, 4);
    step();
    en[2] = 1'b1;
    steps(2);
    cfg_ch = SW'(2);
    cfg_valid = 1'b1; cfg_hi = W'(2); cfg_lo = W'(2);
    track2 = 1;
    step();
    cfg_valid = 1'b0;
    #1 chk("ch2_stall", cfg_ready, 1'b0);
    steps(14);
    chk("ch2_minphase", min2, 2);
    track2 = 0;

    // zero length behaves as one; ch3 disabled during its low phase
    cfg(3, 0, 0);
    step();
    en[3] = 1'b1;
    step();
    chk("ch3_hi0", osc[3], 1'b0);
    steps(2);
    en[3] = 1'b0;
    step();
    chk("ch3_dis_osc", osc[3], 1'b1);
    chk("ch3_dis_tick", tick[3], 1'b1);

    // out-of-range channel is accepted and discarded
    cfg(CH + 1, 9, 9);
    steps(4);

    // reset with an update pending on running ch1
    cfg(1, 7, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_osc", osc, {CH{1'b1}});
    cfg_ch = SW'(1);
    #1 chk("rst2_ready", cfg_ready, 1'b1);
    en = '1;
    step();
    chk("rst2_len", osc[1], 1'b0);
    steps(12);

    // random mix
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) en = CH'($urandom);
      cfg_valid = ($urandom_range(0, 1) == 1);
      cfg_ch    = SW'($urandom_range(0, (1 << SW) - 1));
      cfg_hi    = W'($urandom_range(0, 5));
      cfg_lo    = W'($urandom_range(0, 5));
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; cfg_valid = 1'b0;
    steps(4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
